// File: rtl/ahb_switch_arbiter.sv
// ahb_switch_arbiter: decides which master port owns one slave port of the
// AHB3-Lite multi-layer switch. One instance sits on each slave port.
//   - The highest priority wins. Equal priorities share the port round-robin.
//   - A burst or a locked sequence is never broken.
//   - The grant is registered, so a new owner appears one cycle after the
//     arbitration point.
// Optional feature: define AHB_ARB_STARVE_EN to enable starvation boost.
//   - A requester that loses STARVE_CYCLES arbitration points in a row joins a
//     class that sits above priority 7.
//   - Without the macro the arbiter is pure priority + round-robin.
// The per-master priority port is named prio, because "priority" is a
// reserved word in SystemVerilog.
module ahb_switch_arbiter #(
  parameter int MASTERS       = 3,
  parameter int STARVE_CYCLES = 16,
  localparam int IDXW         = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [MASTERS-1:0]   req,
  input  logic [MASTERS*3-1:0] prio,
  input  logic [MASTERS-1:0]   can_switch,
  input  logic [MASTERS-1:0]   lock,
  input  logic                 HREADY,
  output logic [MASTERS-1:0]   grant,
  output logic [IDXW-1:0]      grant_idx,
  output logic                 switched
);

  logic [MASTERS-1:0] grant_reg;
  logic [IDXW-1:0]    grant_idx_reg;
  logic               switched_reg;
  // rr_ptr_reg is the first index favoured on a priority tie. It points one
  // past the last owner, and points at master 0 after reset.
  logic [IDXW-1:0]    rr_ptr_reg;

  logic               owner_active;
  logic               ap;
  logic               any_req;
  logic [MASTERS-1:0] starved;
  logic [3:0]         cls [MASTERS];
  logic [IDXW-1:0]    win_idx;
  logic [IDXW-1:0]    rr_ptr_next;
  logic [MASTERS-1:0] win_onehot;

  assign grant        = grant_reg;
  assign grant_idx    = grant_idx_reg;
  assign switched     = switched_reg;
  assign owner_active = |grant_reg;
  assign any_req      = |req;

  // Arbitration point: a transfer completes and either:
  //   - there is no owner,
  //   - the owner stopped requesting, or
  //   - the owner is at an unlocked burst boundary.
  assign ap = HREADY & (~owner_active | ~req[grant_idx_reg] |
                        (can_switch[grant_idx_reg] & ~lock[grant_idx_reg]));

  // Effective class per master: the starvation flag on top of the 3-bit priority.
  generate
    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_cls
      assign cls[gi] = {starved[gi], prio[gi*3 +: 3]};
    end
  endgenerate

  // Pick the highest class. The scan starts at the round-robin pointer, so on
  // a tie the earliest index in rotation wins.
  always_comb begin
    logic [IDXW:0] sum;
    logic [IDXW-1:0] cand;
    logic          found;
    logic [3:0]    best;
    found   = 1'b0;
    best    = '0;
    win_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < MASTERS; k++) begin
      sum = {1'b0, rr_ptr_reg} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(MASTERS)) sum = sum - (IDXW+1)'(MASTERS);
      cand = sum[IDXW-1:0];
      if (req[cand] && (!found || cls[cand] > best)) begin
        found   = 1'b1;
        best    = cls[cand];
        win_idx = cand;
      end
    end
  end

  // Derive the winner's one-hot grant and the next round-robin start (winner + 1, wrapped).
  always_comb begin
    logic [IDXW:0] nxt;
    win_onehot  = MASTERS'(1) << win_idx;
    nxt         = {1'b0, win_idx} + (IDXW+1)'(1);
    if (nxt >= (IDXW+1)'(MASTERS)) nxt = '0;
    rr_ptr_next = nxt[IDXW-1:0];
  end

`ifdef AHB_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_CYCLES + 1);
  logic [CW-1:0] starve_cnt_reg [MASTERS];

  generate
    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_starve
      assign starved[gi] = (starve_cnt_reg[gi] == CW'(STARVE_CYCLES));
      // Count the arbitration points this master lost while requesting. Clear
      // on a win or when it stops requesting, and saturate at the limit.
      always_ff @(posedge HCLK) begin
        if (HRESET) begin
          starve_cnt_reg[gi] <= '0;
        end else if (!req[gi]) begin
          starve_cnt_reg[gi] <= '0;
        end else if (ap) begin
          if (win_idx == IDXW'(gi))
            starve_cnt_reg[gi] <= '0;
          else if (!starved[gi])
            starve_cnt_reg[gi] <= starve_cnt_reg[gi] + CW'(1);
        end
      end
    end
  endgenerate
`else
  assign starved = '0;
`endif

  // Grant register. It only moves at arbitration points. With nobody
  // requesting the grant is released, but the index is kept for round-robin.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_reg     <= '0;
      grant_idx_reg <= '0;
      switched_reg  <= 1'b0;
      rr_ptr_reg    <= '0;
    end else begin
      switched_reg <= 1'b0;
      if (ap) begin
        if (any_req) begin
          grant_reg     <= win_onehot;
          grant_idx_reg <= win_idx;
          rr_ptr_reg    <= rr_ptr_next;
          switched_reg  <= (win_onehot != grant_reg);
        end else begin
          grant_reg <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_switch_arbiter.sv
// Testbench for ahb_switch_arbiter (MASTERS=3, STARVE_CYCLES=4).
// Runs directed scenarios with literal expectations, then a randomized phase.
// Every cycle the DUT is compared against a behavioural ownership model.
module tb_ahb_switch_arbiter;
  localparam int M = 3;
  localparam int S = 4;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [2:0] req, can_switch, lock;
  logic [8:0] prio;
  logic       HREADY;
  logic [2:0] grant;
  logic [1:0] grant_idx;
  logic       switched;

  int errors = 0;
  int checks = 0;

  // Model state: the owner index (-1 = none), the last index, the next tie
  // start, the switch pulse and the starvation counts.
  int m_own, m_idx, m_rr, m_sw;
  int m_cnt [M];

  ahb_switch_arbiter #(.MASTERS(M), .STARVE_CYCLES(S)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .prio(prio),
    .can_switch(can_switch), .lock(lock), .HREADY(HREADY),
    .grant(grant), .grant_idx(grant_idx), .switched(switched)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cls_of(input int m);
    int p;
    p = int'(prio[m*3 +: 3]);
`ifdef AHB_ARB_STARVE_EN
    if (m_cnt[m] >= S) p = 8;
`endif
    return p;
  endfunction

  // One clock edge of the abstract ownership rules.
  task automatic model_step();
    int best, w, c;
    bit ap;
    best = -1;
    w = -1;
    if (HRESET) begin
      m_own = -1; m_idx = 0; m_rr = 0; m_sw = 0;
      for (int m = 0; m < M; m++) m_cnt[m] = 0;
    end else begin
      ap = HREADY && (m_own < 0 || !req[m_own] || (can_switch[m_own] && !lock[m_own]));
      m_sw = 0;
      if (ap) begin
        for (int m = 0; m < M; m++)
          if (req[m] && cls_of(m) > best) best = cls_of(m);
        for (int k = 0; k < M; k++) begin
          c = (m_rr + k) % M;
          if (w < 0 && best >= 0 && req[c] && cls_of(c) == best) w = c;
        end
      end
      for (int m = 0; m < M; m++) begin
        if (!req[m]) m_cnt[m] = 0;
        else if (ap && w >= 0) begin
          if (m == w) m_cnt[m] = 0;
          else if (m_cnt[m] < S) m_cnt[m]++;
        end
      end
      if (ap) begin
        if (w >= 0) begin
          m_sw = (w != m_own) ? 1 : 0;
          m_own = w; m_idx = w; m_rr = (w + 1) % M;
        end else begin
          m_own = -1;
        end
      end
    end
  endtask

  task automatic compare_all();
    int eg;
    eg = (m_own < 0) ? 0 : (1 << m_own);
    chk("grant", int'(grant), eg);
    chk("grant_idx", int'(grant_idx), m_idx);
    chk("switched", int'(switched), m_sw);
    chk("onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
  endtask

  // Advance one cycle: model at the rising edge, compare at the falling edge.
  task automatic tick();
    @(posedge HCLK);
    model_step();
    @(negedge HCLK);
    compare_all();
  endtask

  task automatic set_prio(input int p2, input int p1, input int p0);
    prio = {3'(p2), 3'(p1), 3'(p0)};
  endtask

  initial begin
    m_own = -1; m_idx = 0; m_rr = 0; m_sw = 0;
    for (int m = 0; m < M; m++) m_cnt[m] = 0;
    HRESET = 1'b1; req = 3'b111; can_switch = 3'b111; lock = 3'b000;
    HREADY = 1'b1; set_prio(3, 3, 3);

    // Reset held for two cycles, then round-robin among equal priorities.
    tick(); tick();
    chk("rst_grant", int'(grant), 0);
    chk("rst_idx", int'(grant_idx), 0);
    chk("rst_switched", int'(switched), 0);
    HRESET = 1'b0;
    tick(); chk("first_grant", int'(grant), 1); chk("first_sw", int'(switched), 1);
    tick(); chk("rr_1", int'(grant), 2);
    tick(); chk("rr_2", int'(grant), 4);
    tick(); chk("rr_3", int'(grant), 1);

    // Priority: an equal-priority tie, then a higher-priority newcomer.
    set_prio(5, 2, 2); req = 3'b011;
    tick(); chk("prio_tie", int'(grant), 2);
    req = 3'b111;
    tick(); chk("prio_high", int'(grant), 4);

    // Burst hold: a mid-burst owner is not preempted.
    set_prio(3, 7, 3); req = 3'b001;
    tick(); chk("burst_own", int'(grant), 1);
    can_switch = 3'b000; req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("burst_hold", int'(grant), 1);
    end
    can_switch = 3'b111;
    tick(); chk("burst_release", int'(grant), 2);

    // Lock hold: the lock overrides can_switch.
    req = 3'b001;
    tick(); chk("lock_own", int'(grant), 1);
    lock = 3'b001; req = 3'b011;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("lock_hold", int'(grant), 1);
    end
    lock = 3'b000;
    tick(); chk("lock_release", int'(grant), 2);

    // Wait states: the owner drops its request while HREADY is low.
    HREADY = 1'b0; req = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("wait_hold", int'(grant), 2);
    end
    HREADY = 1'b1; req = 3'b100;
    tick(); chk("wait_rearb", int'(grant), 4); chk("wait_idx", int'(grant_idx), 2);
    req = 3'b000;
    tick(); chk("idle_grant", int'(grant), 0); chk("idle_idx", int'(grant_idx), 2);
    chk("idle_sw", int'(switched), 0);

`ifdef AHB_ARB_STARVE_EN
    // Starvation: a low-priority requester wins at its fifth arbitration point.
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0; set_prio(0, 1, 7); req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("starve_wait", int'(grant), 1);
    end
    tick(); chk("starve_boost", int'(grant), 2);
`endif

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      HRESET     = ($urandom_range(0, 59) == 0);
      req        = 3'($urandom);
      if ($urandom_range(0, 3) == 0) prio = 9'($urandom);
      can_switch = 3'(~($urandom & $urandom));
      lock       = 3'($urandom & $urandom & $urandom);
      HREADY     = ($urandom_range(0, 4) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
